// File: rtl/src_opr_wakeup_stage.sv
// src_opr_wakeup_stage: one-entry source operand capture with writeback wakeup.
// Define SRC_WAKEUP_BYPASS_EN to also catch same-cycle writebacks at capture.
module src_opr_wakeup_stage #(
  parameter int DATA_LEN = 32,
  parameter int RRF_SEL  = 6,
  parameter int NUM_SRC  = 2,
  parameter int NUM_WB   = 2
) (
  input  logic                        clk_i,
  input  logic                        reset_i,
  input  logic                        in_valid_i,
  output logic                        in_ready_o,
  input  logic [NUM_SRC-1:0]          arf_busy_i,
  input  logic [NUM_SRC*DATA_LEN-1:0] arf_data_i,
  input  logic [NUM_SRC*RRF_SEL-1:0]  arf_rrftag_i,
  input  logic [NUM_SRC-1:0]          rrf_valid_i,
  input  logic [NUM_SRC*DATA_LEN-1:0] rrf_data_i,
  input  logic [NUM_SRC-1:0]          src_eq_zero_i,
  input  logic [NUM_WB-1:0]           wb_valid_i,
  input  logic [NUM_WB*RRF_SEL-1:0]   wb_rrftag_i,
  input  logic [NUM_WB*DATA_LEN-1:0]  wb_data_i,
  input  logic                        flush_i,
  output logic                        out_valid_o,
  input  logic                        out_ready_i,
  output logic [NUM_SRC*DATA_LEN-1:0] src_o,
  output logic [NUM_SRC-1:0]          src_ready_o,
  output logic                        all_ready_o
);

  logic                valid_q;
  logic [DATA_LEN-1:0] data_q [NUM_SRC];
  logic [NUM_SRC-1:0]  rdy_q;

  logic                capture;
  logic                drain;
  logic                hold;

  logic [DATA_LEN-1:0] cap_data [NUM_SRC];
  logic [NUM_SRC-1:0]  cap_rdy;
  logic [DATA_LEN-1:0] wk_data [NUM_SRC];
  logic [NUM_SRC-1:0]  wk_hit;

  assign in_ready_o = ~valid_q | out_ready_i;
  assign capture    = in_valid_i & in_ready_o;
  assign drain      = valid_q & out_ready_i;
  assign hold       = valid_q & ~out_ready_i;

  // Resolve each incoming source: zero, then ARF, then RRF, else keep tag.
  always_comb begin
    for (int i = 0; i < NUM_SRC; i++) begin
      cap_data[i] = DATA_LEN'(arf_rrftag_i[i*RRF_SEL +: RRF_SEL]);
      cap_rdy[i]  = 1'b0;
      if (src_eq_zero_i[i]) begin
        cap_data[i] = '0;
        cap_rdy[i]  = 1'b1;
      end else if (!arf_busy_i[i]) begin
        cap_data[i] = arf_data_i[i*DATA_LEN +: DATA_LEN];
        cap_rdy[i]  = 1'b1;
      end else if (rrf_valid_i[i]) begin
        cap_data[i] = rrf_data_i[i*DATA_LEN +: DATA_LEN];
        cap_rdy[i]  = 1'b1;
      end
`ifdef SRC_WAKEUP_BYPASS_EN
      else begin
        // Scan high to low so the lowest matching bus wins.
        for (int k = NUM_WB - 1; k >= 0; k--) begin
          if (wb_valid_i[k] &&
              (wb_rrftag_i[k*RRF_SEL +: RRF_SEL] ==
               arf_rrftag_i[i*RRF_SEL +: RRF_SEL])) begin
            cap_data[i] = wb_data_i[k*DATA_LEN +: DATA_LEN];
            cap_rdy[i]  = 1'b1;
          end
        end
      end
`endif
    end
  end

  // Match held not-ready tags against writeback buses, lowest bus wins.
  always_comb begin
    for (int i = 0; i < NUM_SRC; i++) begin
      wk_hit[i]  = 1'b0;
      wk_data[i] = data_q[i];
      for (int k = NUM_WB - 1; k >= 0; k--) begin
        if (!rdy_q[i] && wb_valid_i[k] &&
            (wb_rrftag_i[k*RRF_SEL +: RRF_SEL] ==
             data_q[i][RRF_SEL-1:0])) begin
          wk_hit[i]  = 1'b1;
          wk_data[i] = wb_data_i[k*DATA_LEN +: DATA_LEN];
        end
      end
    end
  end

  // Entry register: reset > flush > capture > drain > wakeup.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      valid_q <= 1'b0;
      rdy_q   <= '0;
      for (int i = 0; i < NUM_SRC; i++) begin
        data_q[i] <= '0;
      end
    end else if (flush_i) begin
      valid_q <= 1'b0;
    end else if (capture) begin
      valid_q <= 1'b1;
      rdy_q   <= cap_rdy;
      for (int i = 0; i < NUM_SRC; i++) begin
        data_q[i] <= cap_data[i];
      end
    end else if (drain) begin
      valid_q <= 1'b0;
    end else if (hold) begin
      for (int i = 0; i < NUM_SRC; i++) begin
        if (wk_hit[i]) begin
          data_q[i] <= wk_data[i];
          rdy_q[i]  <= 1'b1;
        end
      end
    end
  end

  for (genvar g = 0; g < NUM_SRC; g++) begin : g_src
    assign src_o[g*DATA_LEN +: DATA_LEN] = data_q[g];
  end

  assign out_valid_o = valid_q;
  assign src_ready_o = rdy_q;
  assign all_ready_o = &rdy_q;

endmodule

// File: tb/tb_src_opr_wakeup_stage.sv
// tb_src_opr_wakeup_stage: directed and random checks against a reference model.
// Build with SRC_WAKEUP_BYPASS_EN to expect same-cycle capture bypass.
module tb_src_opr_wakeup_stage;

  localparam int DL = 32;
  localparam int RS = 6;
  localparam int NS = 2;
  localparam int NW = 2;

  logic             clk = 1'b0;
  logic             reset = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [NS-1:0]    arf_busy = '0;
  logic [NS*DL-1:0] arf_data = '0;
  logic [NS*RS-1:0] arf_rrftag = '0;
  logic [NS-1:0]    rrf_valid = '0;
  logic [NS*DL-1:0] rrf_data = '0;
  logic [NS-1:0]    src_eq_zero = '0;
  logic [NW-1:0]    wb_valid = '0;
  logic [NW*RS-1:0] wb_rrftag = '0;
  logic [NW*DL-1:0] wb_data = '0;
  logic             flush = 1'b0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [NS*DL-1:0] src;
  logic [NS-1:0]    src_ready;
  logic             all_ready;

  int n_checks = 0;
  int n_errors = 0;

  bit            m_valid = 1'b0;
  logic [DL-1:0] m_data [NS];
  bit            m_rdy [NS];
  bit            m_rst = 1'b0;

  src_opr_wakeup_stage #(
    .DATA_LEN(DL), .RRF_SEL(RS), .NUM_SRC(NS), .NUM_WB(NW)
  ) dut (
    .clk_i(clk),
    .reset_i(reset),
    .in_valid_i(in_valid),
    .in_ready_o(in_ready),
    .arf_busy_i(arf_busy),
    .arf_data_i(arf_data),
    .arf_rrftag_i(arf_rrftag),
    .rrf_valid_i(rrf_valid),
    .rrf_data_i(rrf_data),
    .src_eq_zero_i(src_eq_zero),
    .wb_valid_i(wb_valid),
    .wb_rrftag_i(wb_rrftag),
    .wb_data_i(wb_data),
    .flush_i(flush),
    .out_valid_o(out_valid),
    .out_ready_i(out_ready),
    .src_o(src),
    .src_ready_o(src_ready),
    .all_ready_o(all_ready)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Lowest writeback bus carrying this tag, or -1.
  function automatic int wb_hit(input logic [RS-1:0] tag);
    for (int k = 0; k < NW; k++)
      if (wb_valid[k] && wb_rrftag[k*RS +: RS] == tag) return k;
    return -1;
  endfunction

  task automatic set_src(input int i, input bit eqz, input bit busy,
                         input logic [DL-1:0] arf, input logic [RS-1:0] tag,
                         input bit rv, input logic [DL-1:0] rd);
    src_eq_zero[i]          = eqz;
    arf_busy[i]             = busy;
    arf_data[i*DL +: DL]    = arf;
    arf_rrftag[i*RS +: RS]  = tag;
    rrf_valid[i]            = rv;
    rrf_data[i*DL +: DL]    = rd;
  endtask

  task automatic set_wb(input int k, input bit v, input logic [RS-1:0] tag,
                        input logic [DL-1:0] d);
    wb_valid[k]            = v;
    wb_rrftag[k*RS +: RS]  = tag;
    wb_data[k*DL +: DL]    = d;
  endtask

  // One clock: predict from current inputs, step, compare.
  task automatic cycle();
    bit            rdy_exp;
    bit            n_valid;
    logic [DL-1:0] n_data [NS];
    bit            n_rdy [NS];
    bit            all_exp;
    int            k;
    #1;
    rdy_exp = !m_valid || out_ready;
    check("in_ready", in_ready, rdy_exp);
    n_valid = m_valid;
    n_data  = m_data;
    n_rdy   = m_rdy;
    m_rst   = 1'b0;
    if (reset) begin
      n_valid = 1'b0;
      m_rst   = 1'b1;
      for (int i = 0; i < NS; i++) begin
        n_data[i] = '0;
        n_rdy[i]  = 1'b0;
      end
    end else if (flush) begin
      n_valid = 1'b0;
    end else if (in_valid && rdy_exp) begin
      n_valid = 1'b1;
      for (int i = 0; i < NS; i++) begin
        n_rdy[i] = 1'b1;
        if (src_eq_zero[i]) n_data[i] = 0;
        else if (!arf_busy[i]) n_data[i] = arf_data[i*DL +: DL];
        else if (rrf_valid[i]) n_data[i] = rrf_data[i*DL +: DL];
        else begin
          n_data[i] = {26'd0, arf_rrftag[i*RS +: RS]};
          n_rdy[i]  = 1'b0;
`ifdef SRC_WAKEUP_BYPASS_EN
          k = wb_hit(arf_rrftag[i*RS +: RS]);
          if (k >= 0) begin
            n_data[i] = wb_data[k*DL +: DL];
            n_rdy[i]  = 1'b1;
          end
`endif
        end
      end
    end else if (m_valid && out_ready) begin
      n_valid = 1'b0;
    end else if (m_valid) begin
      for (int i = 0; i < NS; i++) begin
        if (!m_rdy[i]) begin
          k = wb_hit(m_data[i][RS-1:0]);
          if (k >= 0) begin
            n_data[i] = wb_data[k*DL +: DL];
            n_rdy[i]  = 1'b1;
          end
        end
      end
    end
    @(posedge clk);
    #1;
    m_valid = n_valid;
    m_data  = n_data;
    m_rdy   = n_rdy;
    check("out_valid", out_valid, m_valid);
    if (m_valid || m_rst) begin
      all_exp = 1'b1;
      for (int i = 0; i < NS; i++) begin
        check($sformatf("src%0d", i), src[i*DL +: DL], m_data[i]);
        check($sformatf("src_rdy%0d", i), src_ready[i], m_rdy[i]);
        all_exp = all_exp & m_rdy[i];
      end
      check("all_ready", all_ready, all_exp);
    end
  endtask

  int xfers;

  initial begin
    for (int i = 0; i < NS; i++) begin
      m_data[i] = '0;
      m_rdy[i]  = 1'b0;
    end

    reset = 1'b1;
    cycle();
    reset = 1'b0;
    check("rst_valid", out_valid, 0);
    check("rst_src", src, 0);
    check("rst_srdy", src_ready, 0);
    check("rst_all", all_ready, 0);

    set_src(0, 0, 0, 32'h1234, 6'h00, 0, 0);
    set_src(1, 1, 1, 32'hdead, 6'h05, 0, 0);
    in_valid = 1'b1;
    cycle();
    in_valid = 1'b0;
    check("t25_valid", out_valid, 1);
    check("t25_src", src, 64'h0000_0000_0000_1234);
    check("t25_all", all_ready, 1);

    out_ready = 1'b1;
    cycle();
    out_ready = 1'b0;
    check("drain_valid", out_valid, 0);

    set_src(0, 0, 1, 32'h0, 6'h15, 0, 0);
    in_valid = 1'b1;
    cycle();
    in_valid = 1'b0;
    check("t26_cap", src_ready, 2'b10);
    cycle();
    check("t26_tag", src[31:0], 32'h15);
    set_wb(1, 1, 6'h15, 32'hBEEF);
    cycle();
    set_wb(1, 0, 0, 0);
    check("t26_data", src[31:0], 32'hBEEF);
    check("t26_rdy", src_ready[0], 1);

    out_ready = 1'b1;
    cycle();
    out_ready = 1'b0;
    set_src(0, 0, 1, 32'h0, 6'h07, 0, 0);
    set_wb(0, 1, 6'h07, 32'hAA);
    in_valid = 1'b1;
    cycle();
    in_valid = 1'b0;
    set_wb(0, 0, 0, 0);
`ifdef SRC_WAKEUP_BYPASS_EN
    check("t27_data", src[31:0], 32'hAA);
    check("t27_rdy", src_ready[0], 1);
`else
    check("t27_data", src[31:0], 32'h7);
    check("t27_rdy", src_ready[0], 0);
`endif

    out_ready = 1'b1;
    cycle();
    out_ready = 1'b0;
    set_src(0, 0, 1, 32'h0, 6'h03, 0, 0);
    in_valid = 1'b1;
    cycle();
    in_valid = 1'b0;
    set_wb(0, 1, 6'h03, 32'h11);
    set_wb(1, 1, 6'h03, 32'h22);
    cycle();
    set_wb(0, 0, 0, 0);
    set_wb(1, 0, 0, 0);
    check("t28_data", src[31:0], 32'h11);

    xfers = 0;
    out_ready = 1'b1;
    in_valid = 1'b1;
    for (int j = 0; j < 4; j++) begin
      set_src(0, 0, 0, 32'h100 + j, 6'h00, 0, 0);
      cycle();
      if (out_valid) xfers++;
      check("t29_src", src[31:0], 32'h100 + j);
    end
    check("t29_xfers", xfers, 4);
    in_valid = 1'b0;
    cycle();

    out_ready = 1'b0;
    flush = 1'b1;
    in_valid = 1'b1;
    cycle();
    flush = 1'b0;
    check("t30_flush", out_valid, 0);
    cycle();
    in_valid = 1'b0;
    check("t30_hold", out_valid, 1);
    reset = 1'b1;
    cycle();
    reset = 1'b0;
    check("t30_valid", out_valid, 0);
    check("t30_src", src, 0);
    check("t30_srdy", src_ready, 0);
    check("t30_all", all_ready, 0);

    for (int n = 0; n < 600; n++) begin
      reset     = ($urandom_range(0, 63) == 0);
      flush     = ($urandom_range(0, 19) == 0);
      in_valid  = $urandom_range(0, 1) == 1;
      out_ready = ($urandom_range(0, 2) == 0);
      for (int i = 0; i < NS; i++)
        set_src(i, $urandom_range(0, 7) == 0, $urandom_range(0, 3) != 0,
                $urandom, RS'($urandom_range(0, 3)),
                $urandom_range(0, 3) == 0, $urandom);
      for (int k = 0; k < NW; k++)
        set_wb(k, $urandom_range(0, 1) == 1, RS'($urandom_range(0, 3)),
               $urandom);
      cycle();
    end

    $display("Simulation finished: %0d checks, %0d errors",
             n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/src_opr_wakeup_stage.md
SRC_OPR_WAKEUP_STAGE -- requirements
Module: src_opr_wakeup_stage

Interface
REQ-001 SHALL have parameter DATA_LEN, default 32, operand data width.
REQ-002 SHALL have parameter RRF_SEL, default 6, rename-register tag width; RRF_SEL <= DATA_LEN.
REQ-003 SHALL have parameter NUM_SRC, default 2, source operands per instruction.
REQ-004 SHALL have parameter NUM_WB, default 2, writeback broadcast buses snooped.
REQ-005 SHALL have ports: clk_i in 1 clock; reset_i in 1 reset. One clock; reset is synchronous and active-high.
REQ-006 SHALL have in_valid_i in 1 dispatch offers instruction; in_ready_o out 1 stage can accept.
REQ-007 SHALL have arf_busy_i in NUM_SRC, arf_data_i in NUM_SRC*DATA_LEN, arf_rrftag_i in NUM_SRC*RRF_SEL, rrf_valid_i in NUM_SRC, rrf_data_i in NUM_SRC*DATA_LEN, src_eq_zero_i in NUM_SRC; per-source lookup results, source i in slice i.
REQ-008 SHALL have wb_valid_i in NUM_WB, wb_rrftag_i in NUM_WB*RRF_SEL, wb_data_i in NUM_WB*DATA_LEN; writeback buses.
REQ-009 SHALL have flush_i in 1 discard held instruction.
REQ-010 SHALL have out_valid_o out 1; out_ready_i in 1 reservation station accepts; src_o out NUM_SRC*DATA_LEN; src_ready_o out NUM_SRC; all_ready_o out 1 (AND of src_ready_o).

Function
REQ-011 SHALL resolve each source at capture with priority: src_eq_zero -> data 0, ready 1; else ~arf_busy -> arf_data, ready 1; else rrf_valid -> rrf_data, ready 1; else tag zero-extended to DATA_LEN, ready 0.
REQ-012 SHALL hold one instruction; in_ready_o = ~out_valid_o | out_ready_i (combinational).
REQ-013 SHALL capture on in_valid_i & in_ready_o; out_valid_o asserts next cycle (1-cycle latency).
REQ-014 SHALL clear out_valid_o next cycle on out_ready_i with no new capture; capture and drain in same cycle replace the entry with no bubble.
REQ-015 SHALL, each cycle while out_valid_o and no drain, wake each not-ready held source whose stored tag equals wb_rrftag_i[k] with wb_valid_i[k]: data <= wb_data_i[k], ready <= 1 next cycle.
REQ-016 SHALL pick lowest k when several buses match one source; ready sources never change.
REQ-017 SHALL keep src_o, src_ready_o stable while out_valid_o & ~out_ready_i, except wakeup per REQ-015.
REQ-018 SHALL, on flush_i, deassert out_valid_o next cycle and ignore any same-cycle capture; in_ready_o unaffected combinationally by flush_i.
REQ-019 SHALL not gate out_valid_o on all_ready_o; downstream decides issue.

Reset
REQ-020 SHALL on reset_i clear out_valid_o, src_ready_o, src_o, all_ready_o to 0 on the next clk_i edge.
REQ-021 SHALL give reset priority over flush, capture, wakeup; reset mid-hold drops the entry.

Configuration
REQ-022 SHALL support macro SRC_WAKEUP_BYPASS_EN.
REQ-023 With SRC_WAKEUP_BYPASS_EN defined, a source resolving not-ready at capture SHALL also compare against same-cycle wb buses and capture wb data with ready 1 on match (lowest k).
REQ-024 Without it, capture SHALL follow REQ-011 only; a same-cycle writeback is missed and the source waits for a later broadcast.

Verification
REQ-025 Src0 arf_busy=0 data 0x1234, src1 src_eq_zero=1 -> next cycle out_valid_o=1, src_o={0,0x1234}, all_ready_o=1.
REQ-026 Src0 busy, rrf_valid=0, tag 0x15; out_ready_i=0; two cycles later wb_valid[1]=1 tag 0x15 data 0xBEEF -> src0 = 0xBEEF, ready 1 the following cycle.
REQ-027 Src0 busy, tag 0x07, same-cycle wb0 tag 0x07 data 0xAA -> with SRC_WAKEUP_BYPASS_EN src0=0xAA ready 1; without, src0=0x7 ready 0.
REQ-028 Both wb buses match tag 0x03 with data 0x11 (k=0) and 0x22 (k=1) -> src=0x11.
REQ-029 out_valid_o=1, out_ready_i=1, in_valid_i=1 continuously for 4 cycles -> 4 transfers, no bubble.
REQ-030 flush_i=1 with in_valid_i=1, then reset_i mid-hold -> out_valid_o=0 next cycle in both cases, all outputs 0 after reset.
